// File: rtl/wb_sequencer.sv
// Writeback sequencer: queues up to two register writes per request and drains one per cycle
// onto the single register-file write port. Define WB_SEQ_BYPASS_EN to add the byp_* lookup ports.
module wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_en1,
  input  logic [4:0]               req_rd,
  input  logic [XLEN-1:0]          req_data,
  input  logic                     req_en2,
  input  logic [4:0]               req_rs1,
  input  logic [XLEN-1:0]          req_data2,
  output logic                     rf_en,
  output logic [4:0]               waddr,
  output logic [XLEN-1:0]          wdata,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_SEQ_BYPASS_EN
  ,
  input  logic [4:0]               byp_addr,
  output logic                     byp_hit,
  output logic [XLEN-1:0]          byp_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      addr_q [DEPTH];
  logic [4:0]      addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW:0]     count_next_wide;

  logic            accept;
  logic            push1;
  logic            push2;
  logic            pop;
  logic [1:0]      pushed;
  logic [PW-1:0]   slot2;

  // The base update always lands in the slot after the primary, so a same-register pair resolves to the base data.
  always_comb begin
    accept   = req_valid && req_ready;
    push1    = accept && req_en1 && (req_rd != 5'd0);
    push2    = accept && req_en2 && (req_rs1 != 5'd0);
    pop      = (count_q != '0);
    pushed   = {1'b0, push1} + {1'b0, push2};
    slot2    = push1 ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push1) begin
      addr_d[wr_ptr_q] = req_rd;
      data_d[wr_ptr_q] = req_data;
    end
    if (push2) begin
      addr_d[slot2] = req_rs1;
      data_d[slot2] = req_data2;
    end
    wr_ptr_d        = wr_ptr_q + PW'(pushed);
    rd_ptr_d        = rd_ptr_q + PW'(pop);
    count_next_wide = {1'b0, count_q} + (CW+1)'(pushed) - (CW+1)'(pop);
    count_d         = count_next_wide[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Ready needs room for a full pair regardless of what the request actually carries.
  always_comb begin
    req_ready = (((CW+1)'(DEPTH) - {1'b0, count_q}) >= (CW+1)'(2));
    count     = count_q;
    rf_en     = pop;
    waddr     = pop ? addr_q[rd_ptr_q] : 5'd0;
    wdata     = pop ? data_q[rd_ptr_q] : '0;
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - rd_ptr_q} < count_q) begin
        busy_mask[addr_q[i]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

`ifdef WB_SEQ_BYPASS_EN
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (byp_addr != 5'd0) &&
          (addr_q[rd_ptr_q + PW'(k)] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = data_q[rd_ptr_q + PW'(k)];
      end
    end
  end
`endif

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
    count_next_wide <= (CW+1)'(DEPTH));

endmodule
